// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  // funct3 encodings (instruction bits 14:12) for the M extension
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Funct7 value the pipeline controller decodes to route R-type ops here
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_SIGN = 2'b10,
    ST_DONE = 2'b11
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: right-shifting shift-add for
// multiply, or one restoring-division step. acc holds {hi, lo}: for multiply
// {partial product, remaining multiplier}, for divide {remainder, quotient}.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Single shift-add or restoring-subtract step selected by is_div
  always_comb begin
    sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff   = rem_sh - {1'b0, opnd};
    if (is_div) begin
      // top bit of diff is the borrow: remainder was smaller than the divisor
      if (!diff[XLEN]) acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else             acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: IDLE -> CALC (XLEN steps) -> SIGN
// -> DONE, with a single-cycle fast path for divide-by-zero and overflow.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN-1:0]   opnd;
  logic [2:0]        f3;
  logic              neg_main;
  logic              neg_rem;

  logic              accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              fast;
  logic [XLEN-1:0]   fast_res;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, fixed;

  assign ready  = (state == ST_IDLE);
  assign done   = (state == ST_DONE);
  assign accept = ready && start && !flush;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div   (f3[2]),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_step)
  );

  // Operand decode at issue: signed interpretation, magnitudes, fast-path result
  always_comb begin
    logic a_signed, b_signed, div_zero, div_ovf;
    a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg    = a_signed && op_a[XLEN-1];
    b_neg    = b_signed && op_b[XLEN-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    div_zero = funct3[2] && (op_b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (op_a == SMIN) && (op_b == '1);
    fast     = div_zero || div_ovf;
    // funct3[1] distinguishes REM/REMU from DIV/DIVU
    if (div_zero) fast_res = funct3[1] ? op_a : '1;
    else          fast_res = funct3[1] ? '0 : op_a;
  end

  // Sign fixup and word selection applied when leaving CALC
  always_comb begin
    prod = neg_main ? -acc : acc;
    quot = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (f3)
      F3_MUL:                      fixed = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fixed = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             fixed = quot;
      default:                     fixed = rem;
    endcase
  end

  // Control FSM, iteration counter and architectural result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      result <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt <= '0;
            if (fast) begin
              result <= fast_res;
              state  <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (cnt == CNT_LAST) state <= ST_SIGN;
          else                 cnt   <= cnt + 1'b1;
        end
        ST_SIGN: begin
          result <= fixed;
          state  <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath registers: operand capture on accept, one step per CALC cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      f3       <= funct3;
      neg_main <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      if (funct3[2]) begin
        acc  <= {{XLEN{1'b0}}, a_mag};
        opnd <= b_mag;
      end else begin
        acc  <= {{XLEN{1'b0}}, b_mag};
        opnd <= a_mag;
      end
    end else if (state == ST_CALC) begin
      acc <= acc_step;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with an arithmetic reference model and a
// per-cycle compare process tracking done timing, ready and result holding.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        ready;
  logic        done;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .ready  (ready),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          armed = 1'b0;
  bit          pend = 1'b0;
  int          exp_at = 0;
  logic [31:0] exp_res = '0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model straight from the RV32M arithmetic definitions
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'b0, a});
    longint      ub = longint'({32'b0, b});
    logic [63:0] p;
    bit          ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      F3_MUL:    begin p = ua * ub; return p[31:0];  end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      F3_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      F3_DIVU:   begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      F3_REM:    begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default:   begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Per-cycle compare against the expectation posted by the driver
  always @(negedge clk) begin
    if (armed) begin
      if (pend) begin
        check("ready_busy", {31'b0, ready}, 32'd0);
        if (cyc == exp_at) begin
          check("done_pulse", {31'b0, done}, 32'd1);
          check("result", result, exp_res);
          last_res = exp_res;
          pend = 1'b0;
        end else begin
          check("done_early", {31'b0, done}, 32'd0);
          check("result_hold_busy", result, last_res);
        end
      end else begin
        check("ready_idle", {31'b0, ready}, 32'd1);
        check("done_idle", {31'b0, done}, 32'd0);
        check("result_hold", result, last_res);
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int hold);
    wait_ready();
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    exp_res = model(f, a, b);
    exp_at  = cyc + (is_fast(f, a, b) ? 0 : 33);
    pend    = 1'b1;
    // scramble the inputs so anything not latched at accept shows up
    funct3 = ~f; op_a = ~a; op_b = b + 32'd3;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (pend && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (pend) begin
      check("done_timeout", 32'd0, 32'd1);
      pend = 1'b0;
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want, input int hold);
    check("model_pin", model(f, a, b), want);
    issue(f, a, b, hold);
    wait_done();
    #1 check("result_literal", result, want);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want;
  } vec_t;

  vec_t vecs[21] = '{
    '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
    '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
    '{F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
    '{F3_DIVU,   32'd100,        32'd7,         32'd14},
    '{F3_REMU,   32'd100,        32'd7,         32'd2},
    '{F3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF},
    '{F3_REM,    32'd5,          32'd0,         32'd5},
    '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
    '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
    '{F3_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD},
    '{F3_REM,    32'd7,          32'hFFFF_FFFE, 32'd1},
    '{F3_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF},
    '{F3_MULH,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF},
    '{F3_REMU,   32'd5,          32'd0,         32'd5},
    '{F3_MULHU,  32'h8000_0000,  32'd2,         32'd1},
    '{F3_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1},
    '{F3_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
    '{F3_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000}
  };

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'b0, ready}, 32'd1);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    armed = 1'b1;

    for (int i = 0; i < 21; i++)
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].want, 0);

    // start held high through a busy operation must not queue a second one
    run_op(F3_DIVU, 32'd1000, 32'd9, 32'd111, 20);

    // flush at CALC cycle 10: back to IDLE, no done, result unchanged
    issue(F3_MUL, 32'd3, 32'd5, 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    pend  = 1'b0;
    check("flush_ready", {31'b0, ready}, 32'd1);
    repeat (40) @(negedge clk);

    // start and flush together in IDLE: request dropped
    @(negedge clk);
    funct3 = F3_MUL; op_a = 32'd9; op_b = 32'd9;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("start_flush_ready", {31'b0, ready}, 32'd1);
    repeat (40) @(negedge clk);

    // asynchronous reset in the middle of CALC
    issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    pend = 1'b0;
    last_res = 32'd0;
    #1;
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);

    run_op(F3_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 0);

    armed = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
